// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port in front of a little-endian word RAM,
// with RV32I size decoding, wait states and error flagging. Define DMEM_ZERO_INIT_EN to clear the RAM after reset.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

`ifdef DMEM_ZERO_INIT_EN
  typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} state_t;
  logic [MEM_AW-1:0] clr_ptr;
`else
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`endif

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       mem [DEPTH];

  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [2:0]        lat_funct3;
  logic [31:0]       lat_wdata;

  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        acc_funct3;
  logic [31:0]       acc_wdata;
  logic [31:0]       word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic [31:0]       rd_word;
  logic              err;
  logic              enter_resp;
  logic [31:0]       rsp_rdata_nxt;

  function automatic logic access_err(input logic wr, input logic [2:0] f3,
                                      input logic [1:0] lane, input logic ok_range);
    logic bad_f3;
    logic misaligned;
    if (wr) bad_f3 = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
    else    bad_f3 = (f3 == 3'b011 || f3[2:1] == 2'b11);
    misaligned = (f3[1:0] == 2'b01 && lane[0]) || (f3[1:0] == 2'b10 && lane != 2'b00);
    return bad_f3 || misaligned || !ok_range;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return word;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    case (f3)
      3'b000:  m[{lane, 3'b000} +: 8]    = wd[7:0];
      3'b001:  m[{lane[1], 4'b0000} +: 16] = wd[15:0];
      3'b010:  m = wd;
      default: m = word;
    endcase
    return m;
  endfunction

  // With zero wait states the access runs on the accept edge, so it must use the live request.
  always_comb begin
    acc_write  = lat_write;
    acc_addr   = lat_addr;
    acc_funct3 = lat_funct3;
    acc_wdata  = lat_wdata;
    if (state == IDLE) begin
      acc_write  = req_write;
      acc_addr   = req_addr;
      acc_funct3 = req_funct3;
      acc_wdata  = req_wdata;
    end
  end

  assign word_idx      = 32'(acc_addr) >> 2;
  assign in_range      = word_idx < 32'(DEPTH);
  assign mem_idx       = in_range ? word_idx[MEM_AW-1:0] : '0;
  assign rd_word       = mem[mem_idx];
  assign err           = access_err(acc_write, acc_funct3, acc_addr[1:0], in_range);
  assign rsp_rdata_nxt = (err || acc_write) ? 32'h0 : load_extend(rd_word, acc_funct3, acc_addr[1:0]);
  assign enter_resp    = !reset && ((state == IDLE && req_valid && NO_WAIT) ||
                                    (state == WAIT && cnt == '0));
  assign req_ready     = (state == IDLE);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DMEM_ZERO_INIT_EN
      state   <= CLEAR;
      clr_ptr <= '0;
`else
      state   <= IDLE;
`endif
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          if (NO_WAIT) state <= RESP;
          else         state <= WAIT;
          cnt <= CNT_W'(WAIT_CYCLES);
        end
        WAIT: if (cnt == '0) state <= RESP;
              else           cnt   <= cnt - 1'b1;
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
`ifdef DMEM_ZERO_INIT_EN
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == MEM_AW'(DEPTH - 1)) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= rsp_rdata_nxt;
        rsp_err   <= err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && req_valid) begin
      lat_write  <= req_write;
      lat_addr   <= req_addr;
      lat_funct3 <= req_funct3;
      lat_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
`ifdef DMEM_ZERO_INIT_EN
    if (!reset && state == CLEAR)
      mem[clr_ptr] <= 32'h0;
    else
`endif
    if (enter_resp && acc_write && !err)
      mem[mem_idx] <= store_merge(rd_word, acc_wdata, acc_funct3, acc_addr[1:0]);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (ADDR_W=9, DEPTH=64, WAIT_CYCLES=2) with hand-computed expectations.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [8:0]  req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  dmem_responder #(.ADDR_W(9), .DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request and return #1 after the edge that accepts it.
  task automatic start_req(input logic wr, input logic [8:0] addr, input logic [2:0] f3,
                           input logic [31:0] wd);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_funct3 = f3; req_wdata = wd;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = 9'h1ff; req_wdata = 32'hxxxx_xxxx; req_funct3 = 3'b111;
  endtask

  // Edges from acceptance until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 1;
    @(posedge clk); #1;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [8:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    start_req(wr, addr, f3, wd);
    wait_rsp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
    finish_rsp();
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
`ifdef DMEM_ZERO_INIT_EN
    chk(tag, 32'(n), 32'd64);
`else
    chk(tag, 32'(n), 32'd0);
`endif
  endtask

  logic [31:0] held_rd;
  logic        held_err;
  int          lat;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_funct3 = 3'b010; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'h0, rsp_err}, 32'h0);
`ifdef DMEM_ZERO_INIT_EN
    chk("rst_busy", {31'h0, busy}, 32'h1);
`else
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
`endif
    reset = 1'b0;
    wait_clear("init_clear_cycles");

    do_req("sw_20_old", 1'b1, 9'h020, 3'b010, 32'h1111_1111, 32'h0, 1'b0);
    do_req("sw_00",     1'b1, 9'h000, 3'b010, 32'h0BAD_F00D, 32'h0, 1'b0);
    do_req("sw_10",     1'b1, 9'h010, 3'b010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_req("lw_10",     1'b0, 9'h010, 3'b010, 32'h0,         32'hDEAD_BEEF, 1'b0);
    do_req("lb_13",     1'b0, 9'h013, 3'b000, 32'h0,         32'hFFFF_FFDE, 1'b0);
    do_req("lbu_13",    1'b0, 9'h013, 3'b100, 32'h0,         32'h0000_00DE, 1'b0);
    do_req("lh_12",     1'b0, 9'h012, 3'b001, 32'h0,         32'hFFFF_DEAD, 1'b0);
    do_req("lhu_10",    1'b0, 9'h010, 3'b101, 32'h0,         32'h0000_BEEF, 1'b0);
    do_req("lb_10",     1'b0, 9'h010, 3'b000, 32'h0,         32'hFFFF_FFEF, 1'b0);
    do_req("sb_11",     1'b1, 9'h011, 3'b000, 32'hFFFF_FF55, 32'h0, 1'b0);
    do_req("lw_sb",     1'b0, 9'h010, 3'b010, 32'h0,         32'hDEAD_55EF, 1'b0);
    do_req("sh_12",     1'b1, 9'h012, 3'b001, 32'hFFFF_1234, 32'h0, 1'b0);
    do_req("lw_sh",     1'b0, 9'h010, 3'b010, 32'h0,         32'h1234_55EF, 1'b0);

    do_req("err_lw_11",  1'b0, 9'h011, 3'b010, 32'h0,         32'h0, 1'b1);
    do_req("err_lh_13",  1'b0, 9'h013, 3'b001, 32'h0,         32'h0, 1'b1);
    do_req("err_sw_100", 1'b1, 9'h100, 3'b010, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_req("err_lw_100", 1'b0, 9'h100, 3'b010, 32'h0,         32'h0, 1'b1);
    do_req("err_ld_011", 1'b0, 9'h010, 3'b011, 32'h0,         32'h0, 1'b1);
    do_req("err_st_011", 1'b1, 9'h010, 3'b011, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_req("err_sw_12",  1'b1, 9'h012, 3'b010, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_req("err_sh_11",  1'b1, 9'h011, 3'b001, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_req("lw_10_kept", 1'b0, 9'h010, 3'b010, 32'h0,         32'h1234_55EF, 1'b0);
    do_req("lw_00_kept", 1'b0, 9'h000, 3'b010, 32'h0,         32'h0BAD_F00D, 1'b0);

    // Backpressure with a second request held on the port.
    start_req(1'b0, 9'h010, 3'b010, 32'h0);
    wait_rsp(lat);
    chk("bp_lat", 32'(lat), 32'd3);
    held_rd  = rsp_rdata;
    held_err = rsp_err;
    chk("bp_rdata", held_rd, 32'h1234_55EF);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h000; req_funct3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", {31'h0, rsp_valid}, 32'h1);
      chk("bp_rdata_hold", rsp_rdata, held_rd);
      chk("bp_err_hold", {31'h0, rsp_err}, {31'h0, held_err});
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
    end
    finish_rsp();
    chk("bp_idle_ready", {31'h0, req_ready}, 32'h1);
    chk("bp_idle_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk); #1;
    chk("bp_second_accepted", {31'h0, busy}, 32'h1);
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("bp_second_lat", 32'(lat), 32'd3);
    chk("bp_second_rdata", rsp_rdata, 32'h0BAD_F00D);
    finish_rsp();

    // Reset while a store waits: the store must be dropped.
    start_req(1'b1, 9'h020, 3'b010, 32'hA5A5_A5A5);
    chk("mid_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
`ifdef DMEM_ZERO_INIT_EN
    chk("mid_req_ready", {31'h0, req_ready}, 32'h0);
`else
    chk("mid_req_ready", {31'h0, req_ready}, 32'h1);
`endif
    wait_clear("mid_clear_cycles");
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_rsp", {31'h0, rsp_valid}, 32'h0);
`ifdef DMEM_ZERO_INIT_EN
    do_req("lw_20_after", 1'b0, 9'h020, 3'b010, 32'h0, 32'h0, 1'b0);
`else
    do_req("lw_20_after", 1'b0, 9'h020, 3'b010, 32'h0, 32'h1111_1111, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
